// File: rtl/frame_stream_seq.sv
// Multi-frame raster sequencer: reads frames from a 1-cycle-latency frame store and
// streams them to CHIP with start/valid framing, stall support and ready handshaking.
module frame_stream_seq #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int NUM_FRAMES = 3,
    parameter int PIX_W      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int LOOP       = 0,
    parameter int ADDR_W     = $clog2(NUM_FRAMES * WIDTH * HEIGHT),
    localparam int FIDX_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_go,
    input  logic              i_abort,
    input  logic              i_stall,
    input  logic              i_chip_ready,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [PIX_W-1:0]  i_mem_data,
    output logic [PIX_W-1:0]  o_pixel,
    output logic              o_valid,
    output logic              o_start,
    output logic [FIDX_W-1:0] o_frame_idx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int FRAME_PIX = WIDTH * HEIGHT;
    localparam int PIX_CW    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_STREAM, S_DRAIN, S_GAP, S_WAIT_RDY, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PIX_CW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [FIDX_W-1:0]   frame_q, frame_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                drain_q, drain_d;
    logic                rd;
    logic [ADDR_W-1:0]   rd_addr;

    // Stage 1 tracks the read whose data is on i_mem_data; stage 2 is the output register.
    logic [2:1]          vld_pipe_q;
    logic [2:1]          sop_pipe_q;
    logic [PIX_W-1:0]    pixel_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            frame_q   <= '0;
            gap_cnt_q <= '0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            frame_q   <= frame_d;
            gap_cnt_q <= gap_cnt_d;
            drain_q   <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        frame_d   = frame_q;
        gap_cnt_d = gap_cnt_q;
        drain_d   = drain_q;
        rd        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    state_d   = S_STREAM;
                    pix_cnt_d = '0;
                    frame_d   = '0;
                end
            end
            S_STREAM: begin
                if (!i_stall) begin
                    rd = 1'b1;
                    if (pix_cnt_q == PIX_CW'(FRAME_PIX - 1)) begin
                        pix_cnt_d = '0;
                        drain_d   = 1'b0;
                        state_d   = S_DRAIN;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? S_GAP : S_WAIT_RDY;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = S_WAIT_RDY;
                else                               gap_cnt_d = gap_cnt_q + 1'b1;
            end
            S_WAIT_RDY: begin
                if (i_chip_ready) begin
                    if (frame_q != FIDX_W'(NUM_FRAMES - 1)) begin
                        frame_d = frame_q + 1'b1;
                        state_d = S_STREAM;
                    end else if (LOOP != 0) begin
                        frame_d = '0;
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                frame_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a go seen in the same IDLE cycle.
        if (i_abort) begin
            state_d   = S_IDLE;
            pix_cnt_d = '0;
            frame_d   = '0;
        end
    end

    assign rd_addr = ADDR_W'(frame_q) * ADDR_W'(FRAME_PIX) + ADDR_W'(pix_cnt_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe_q <= '0;
            sop_pipe_q <= '0;
            pixel_q    <= '0;
        end else if (i_abort) begin
            vld_pipe_q <= '0;
            sop_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1], rd};
            sop_pipe_q <= {sop_pipe_q[1], rd && (pix_cnt_q == '0)};
            if (vld_pipe_q[1]) pixel_q <= i_mem_data;
        end
    end

    assign o_mem_rd    = rd;
    assign o_mem_addr  = rd ? rd_addr : '0;
    assign o_pixel     = pixel_q;
    assign o_valid     = vld_pipe_q[2];
    assign o_start     = sop_pipe_q[2];
    assign o_frame_idx = frame_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);

endmodule
